operand_fetch: RTL and testbench

//  Operand-fetch stage feeding the 8-bit ALU (op1/op2/func). Holds the 8x8-bit register file,

---
 rtl/operand_fetch.sv | 134 +++++++++++++
 tb/tb_operand_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand-fetch stage: 8-entry register file, busy scoreboard and a one-entry
// valid/ready output register toward the ALU. Define OPFETCH_STATS_EN to add issue/stall counters.
module operand_fetch #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int FUNC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic [FUNC_W-1:0] func,
  output logic [REG_AW-1:0] out_rd,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data
`ifdef OPFETCH_STATS_EN
  ,
  output logic [15:0]       stat_issue,
  output logic [15:0]       stat_stall
`endif
);

  localparam int NREG = 2 ** REG_AW;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [DATA_W-1:0] rf [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  logic              vld_p0;
  logic [DATA_W-1:0] op1_p0;
  logic [DATA_W-1:0] op2_p0;
  logic [FUNC_W-1:0] func_p0;
  logic [REG_AW-1:0] rd_p0;

  logic              rs_byp;
  logic              rt_byp;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              hazard;
  logic              accept;

  // Source resolution: r0 is hard zero, a same-cycle write-back is forwarded.
  always_comb begin
    rs_byp = wb_en && (wb_rd == in_rs) && (in_rs != '0);
    rt_byp = wb_en && (wb_rd == in_rt) && (in_rt != '0);
    if (in_rs == '0)  rs_val = '0;
    else if (rs_byp)  rs_val = wb_data;
    else              rs_val = rf[in_rs];
    if (in_rt == '0)  rt_val = '0;
    else if (rt_byp)  rt_val = wb_data;
    else              rt_val = rf[in_rt];
    hazard = (busy[in_rs] && !rs_byp) || (!in_use_imm && busy[in_rt] && !rt_byp);
  end

  assign in_ready = !hazard && (!vld_p0 || out_ready);
  assign accept   = in_valid && in_ready;

  // Set on issue overrides clear from write-back to the same register.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)
      busy_nxt[wb_rd] = 1'b0;
    if (accept && (in_rd != '0))
      busy_nxt[in_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
      busy <= '0;
    end else begin
      if (wb_en && (wb_rd != '0))
        rf[wb_rd] <= wb_data;
      busy <= busy_nxt;
    end
  end

  // ---- stage p0: output register toward the ALU ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      op1_p0  <= '0;
      op2_p0  <= '0;
      func_p0 <= '0;
      rd_p0   <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      op1_p0  <= rs_val;
      op2_p0  <= in_use_imm ? in_imm : rt_val;
      func_p0 <= in_func;
      rd_p0   <= in_rd;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign op1       = op1_p0;
  assign op2       = op2_p0;
  assign func      = func_p0;
  assign out_rd    = rd_p0;

`ifdef OPFETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (accept)
        stat_issue <= sat_inc(stat_issue);
      if (in_valid && !in_ready)
        stat_stall <= sat_inc(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic checked
// against a register-file/scoreboard reference model.
module tb_operand_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_rs, in_rt, in_rd;
  logic [2:0] in_func;
  logic [7:0] in_imm;
  logic       in_use_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] op1, op2;
  logic [2:0] func;
  logic [2:0] out_rd;
  logic       wb_en;
  logic [2:0] wb_rd;
  logic [7:0] wb_data;

  operand_fetch #(.DATA_W(8), .REG_AW(3), .FUNC_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_func(in_func),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .func(func), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic seen_rdy;

  // Reference model: architectural register values, pending-write set, output slot.
  logic [7:0] m_rf [8];
  bit         m_pending [8];
  bit         m_vld;
  logic [7:0] m_op1, m_op2;
  logic [2:0] m_func, m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 8'h00;
      m_pending[i] = 1'b0;
    end
    m_vld = 0; m_op1 = 0; m_op2 = 0; m_func = 0; m_rd = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] r);
    if (r == 0) return 8'h00;
    if (wb_en && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit m_avail(input logic [2:0] r);
    return !m_pending[r] || (r != 0 && wb_en && wb_rd == r);
  endfunction

  function automatic bit m_ready();
    bit ops_ok;
    ops_ok = m_avail(in_rs) && (in_use_imm || m_avail(in_rt));
    return ops_ok && (!m_vld || out_ready);
  endfunction

  task automatic cycle();
    bit rdy, acc;
    @(negedge clk);
    rdy = m_ready();
    seen_rdy = in_ready;
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    acc = in_valid && rdy;
    if (acc) begin
      m_vld = 1; m_op1 = m_read(in_rs);
      m_op2 = in_use_imm ? in_imm : m_read(in_rt);
      m_func = in_func; m_rd = in_rd;
    end else if (out_ready) begin
      m_vld = 0;
    end
    if (wb_en) begin
      if (wb_rd != 0) m_rf[wb_rd] = wb_data;
      m_pending[wb_rd] = 1'b0;
    end
    if (acc && in_rd != 0) m_pending[in_rd] = 1'b1;
    #1;
    chk("out_valid", out_valid, m_vld);
    chk("op1", op1, m_op1);
    chk("op2", op2, m_op2);
    chk("func", func, m_func);
    chk("out_rd", out_rd, m_rd);
  endtask

  task automatic issue(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                       input logic [2:0] f, input logic [7:0] imm, input logic ui);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_func = f; in_imm = imm; in_use_imm = ui;
  endtask

  task automatic wb(input logic en, input logic [2:0] rd, input logic [7:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_func = 0; in_imm = 0; in_use_imm = 0;
    wb(0, 0, 0);
  endtask

  logic [7:0] h1, h2;
  logic [2:0] hf;

  initial begin
    idle();
    out_ready = 1;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_op1", op1, 8'h00);
    chk("rst_op2", op2, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);

    // Write then read
    wb(1, 3, 8'h5A); cycle();
    wb(0, 0, 0); issue(3, 0, 0, 3'd5, 8'h00, 0); cycle();
    chk("wr_op1", op1, 8'h5A);
    chk("wr_op2", op2, 8'h00);
    chk("wr_valid", out_valid, 1'b1);
    idle(); cycle();

    // Same-cycle bypass
    issue(2, 0, 0, 3'd1, 8'h00, 0); wb(1, 2, 8'hC3); cycle();
    chk("byp_ready", seen_rdy, 1'b1);
    chk("byp_op1", op1, 8'hC3);
    idle(); cycle();

    // Hazard on pending destination
    issue(0, 0, 4, 3'd2, 8'h00, 0); cycle();
    issue(4, 0, 0, 3'd3, 8'h00, 0); cycle();
    chk("haz_stall", seen_rdy, 1'b0);
    wb(1, 4, 8'h11); cycle();
    chk("haz_release", seen_rdy, 1'b1);
    chk("haz_op1", op1, 8'h11);
    idle(); cycle();

    // Backpressure
    wb(1, 5, 8'hA7); issue(5, 3, 0, 3'd6, 8'h00, 0); cycle();
    h1 = op1; h2 = op2; hf = func;
    chk("bp_op1_val", h1, 8'hA7);
    out_ready = 0; wb(0, 0, 0); issue(1, 2, 0, 3'd7, 8'h00, 0);
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("bp_ready", seen_rdy, 1'b0);
      chk("bp_op1_hold", op1, h1);
      chk("bp_op2_hold", op2, h2);
      chk("bp_func_hold", func, hf);
    end
    out_ready = 1; cycle();
    chk("bp_resume", seen_rdy, 1'b1);
    chk("bp_new_op2", op2, 8'hC3);
    idle(); cycle();

    // r0 and immediate with busy rt
    issue(0, 0, 6, 3'd0, 8'h00, 0); cycle();
    idle(); wb(1, 0, 8'hFF); issue(0, 6, 0, 3'd4, 8'h7E, 1); cycle();
    chk("imm_ready", seen_rdy, 1'b1);
    chk("imm_op1", op1, 8'h00);
    chk("imm_op2", op2, 8'h7E);
    idle(); wb(1, 6, 8'h00); cycle();
    idle(); cycle();

    // Reset in the middle of a held transfer
    issue(3, 5, 7, 3'd2, 8'h00, 0); cycle();
    out_ready = 0; idle(); cycle();
    #1 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_op1", op1, 8'h00);
    chk("mid_rst_op2", op2, 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1; out_ready = 1;
    for (int r = 1; r < 8; r++) begin
      issue(3'(r), 3'(r), 0, 3'd0, 8'h00, 0); cycle();
      chk("rst_rf_op1", op1, 8'h00);
      chk("rst_rf_op2", op2, 8'h00);
    end
    idle(); cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs      = 3'($urandom_range(0, 7));
      in_rt      = 3'($urandom_range(0, 7));
      in_rd      = 3'($urandom_range(0, 7));
      in_func    = 3'($urandom_range(0, 7));
      in_imm     = 8'($urandom_range(0, 255));
      in_use_imm = ($urandom_range(0, 2) == 0);
      wb_en      = ($urandom_range(0, 1) == 1);
      wb_rd      = 3'($urandom_range(0, 7));
      wb_data    = 8'($urandom_range(0, 255));
      out_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
